// File: rtl/i2c_slave_regfile.sv
// ---------------------------------------------------------------------------
// i2c_slave_regfile
//
// I2C target that oversamples SCL/SDA on the system clock, decodes START,
// STOP and repeated START, acknowledges its own 7-bit address and exposes a
// byte-wide register file with an auto-incrementing register pointer.
//
// Frames handled:
//   write : S, ADDR+W, REG, DATA.., P
//   read  : S, ADDR+W, REG, Sr, ADDR+R, DATA.., P
//           (S, ADDR+R, DATA.., P reads from the current pointer)
//
// Ports:
//   clk         system clock; each SCL phase must span at least 4 clk
//   reset_n     asynchronous active-low reset
//   scl_in      I2C clock from the bus (asynchronous)
//   sda_in      I2C data from the bus (asynchronous)
//   sda_oe      1 = pull SDA low, 0 = release the line
//   host_addr   local read index into the register file
//   host_rdata  register byte at host_addr (combinational)
//   wr_pulse    one-clk strobe when a byte is written from the bus
//   wr_addr     register index written, valid with wr_pulse
//   wr_data     byte written, valid with wr_pulse
//   busy        high from an addressed START until STOP or an address NACK
// ---------------------------------------------------------------------------
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         REG_AW     = 4,
    parameter logic [7:0] RESET_VAL  = 8'h00
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    input  logic [REG_AW-1:0] host_addr,
    output logic [7:0]        host_rdata,
    output logic              wr_pulse,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int DEPTH = 1 << REG_AW;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_REG   = 3'd2;
    localparam logic [2:0] ST_WDATA = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;

    logic              scl_s1, scl_s2, scl_d;
    logic              sda_s1, sda_s2, sda_d;
    logic              scl_rise, scl_fall, start_det, stop_det;

    logic [2:0]        state;
    logic [3:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic [7:0]        byte_in;
    logic              rw;
    logic [REG_AW-1:0] pointer;
    logic [REG_AW-1:0] ptr_next;
    logic [7:0]        regfile [DEPTH];

    // Two-flop synchronisers plus one history flop per line. They reset to 1
    // (idle bus level) so that reset release on an idle bus creates no edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    // Bus events: SDA may only change while SCL is low, so an SDA edge seen
    // with SCL high on both sides of it is a START or a STOP.
    assign scl_rise  =  scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 &  scl_d;
    assign start_det =  scl_s2 &  scl_d &  sda_d & ~sda_s2;
    assign stop_det  =  scl_s2 &  scl_d & ~sda_d &  sda_s2;

    assign byte_in    = {shift_reg[6:0], sda_s2};
    assign ptr_next   = pointer + REG_AW'(1);
    assign host_rdata = regfile[host_addr];

    // Protocol engine. bit_cnt counts the SCL rises of the current 9-bit
    // slot: 0..7 are data bits, 8 means the byte is complete and the next
    // rise is the acknowledge bit. In the write direction SDA is pulled low
    // for the ACK slot only while the byte was accepted (a mismatched
    // address leaves ADDR before the ACK slot). In RDATA the shift register
    // is shifted on every rise so its MSB is always the next bit to drive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'h00;
            rw        <= 1'b0;
            pointer   <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                regfile[i] <= RESET_VAL;
            end
        end else begin
            wr_pulse <= 1'b0;
            if (stop_det) begin
                state   <= ST_IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
            end else if (state != ST_IDLE) begin
                if (scl_rise) begin
                    if (bit_cnt != 4'd8) begin
                        shift_reg <= byte_in;
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            case (state)
                                ST_ADDR: begin
                                    if (byte_in[7:1] == SLAVE_ADDR) begin
                                        busy <= 1'b1;
                                        rw   <= byte_in[0];
                                    end else begin
                                        busy    <= 1'b0;
                                        state   <= ST_IDLE;
                                        bit_cnt <= 4'd0;
                                    end
                                end
                                ST_REG: begin
                                    pointer <= byte_in[REG_AW-1:0];
                                end
                                ST_WDATA: begin
                                    regfile[pointer] <= byte_in;
                                    wr_pulse         <= 1'b1;
                                    wr_addr          <= pointer;
                                    wr_data          <= byte_in;
                                    pointer          <= ptr_next;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end else begin
                        bit_cnt <= 4'd0;
                        case (state)
                            ST_ADDR: begin
                                if (rw) begin
                                    state     <= ST_RDATA;
                                    shift_reg <= regfile[pointer];
                                end else begin
                                    state <= ST_REG;
                                end
                            end
                            ST_REG: begin
                                state <= ST_WDATA;
                            end
                            ST_RDATA: begin
                                pointer <= ptr_next;
                                if (!sda_s2) begin
                                    shift_reg <= regfile[ptr_next];
                                end else begin
                                    state  <= ST_IDLE;
                                    sda_oe <= 1'b0;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end else if (scl_fall) begin
                    if (state == ST_RDATA) begin
                        sda_oe <= (bit_cnt == 4'd8) ? 1'b0 : ~shift_reg[7];
                    end else begin
                        sda_oe <= (bit_cnt == 4'd8);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_regfile
//
// Bit-banged I2C master driving i2c_slave_regfile over a wired-AND SDA line.
// A register-array model with a pointer predicts ACKs, read bytes, write
// strobes and the register contents for directed and random frames.
// ---------------------------------------------------------------------------
module tb_i2c_slave_regfile;

    localparam logic [6:0] SLAVE_ADDR = 7'h50;
    localparam int         REG_AW     = 4;
    localparam logic [7:0] RESET_VAL  = 8'h00;
    localparam int         DEPTH      = 16;
    localparam int         Q          = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              scl_m;
    logic              sda_m;
    logic              bus_sda;
    logic              sda_oe;
    logic [REG_AW-1:0] host_addr;
    logic [7:0]        host_rdata;
    logic              wr_pulse;
    logic [REG_AW-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  model_regs [DEPTH];
    int          model_ptr;
    logic [7:0]  tx_buf [8];
    logic [11:0] wr_q [$];
    logic [11:0] exp_q [$];

    // Free-running system clock.
    always #5 clk = ~clk;

    // Open-drain bus: either side can pull SDA low.
    assign bus_sda = sda_m & ~sda_oe;

    i2c_slave_regfile #(
        .SLAVE_ADDR (SLAVE_ADDR),
        .REG_AW     (REG_AW),
        .RESET_VAL  (RESET_VAL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scl_in     (scl_m),
        .sda_in     (bus_sda),
        .sda_oe     (sda_oe),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .wr_pulse   (wr_pulse),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    // Records every write strobe seen from the bus side.
    always @(negedge clk) begin
        if (reset_n && wr_pulse) begin
            wr_q.push_back({wr_addr, wr_data});
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(input logic b, output logic s);
        sda_m = b;
        waitClk(Q);
        scl_m = 1'b1;
        waitClk(Q);
        s = bus_sda;
        waitClk(Q);
        scl_m = 1'b0;
        waitClk(Q);
    endtask

    task automatic busStart;
        sda_m = 1'b1;
        waitClk(Q);
        scl_m = 1'b1;
        waitClk(2 * Q);
        sda_m = 1'b0;
        waitClk(2 * Q);
        scl_m = 1'b0;
        waitClk(Q);
    endtask

    task automatic busStop;
        sda_m = 1'b0;
        waitClk(Q);
        scl_m = 1'b1;
        waitClk(2 * Q);
        sda_m = 1'b1;
        waitClk(2 * Q);
    endtask

    task automatic busWriteByte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            sendBit(b[i], s);
        end
        sendBit(1'b1, s);
        ack = ~s;
    endtask

    task automatic busReadByte(output logic [7:0] b, input logic master_ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            sendBit(1'b1, s);
            b[i] = s;
        end
        sendBit(~master_ack, s);
    endtask

    task automatic checkWrites(input string tag);
        checkOutput({tag, "_wr_count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            checkOutput({tag, "_wr_event"}, wr_q[i], exp_q[i]);
        end
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic checkRegs(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            host_addr = REG_AW'(i);
            #1;
            checkOutput(tag, host_rdata, model_regs[i]);
        end
    endtask

    // kind 0: write frame, kind 1: set pointer + Sr + read, kind 2: read at
    // the current pointer. Each frame ends with a STOP and full checking.
    task automatic applyStimulus(input int kind, input logic [6:0] addr7,
                                 input logic [7:0] reg_byte, input int len);
        logic       ack;
        logic       match;
        logic [7:0] rb;
        match = (addr7 == SLAVE_ADDR);
        wr_q.delete();
        busStart;
        if (kind != 2) begin
            busWriteByte({addr7, 1'b0}, ack);
            checkOutput("addr_w_ack", ack, match);
            busWriteByte(reg_byte, ack);
            checkOutput("reg_ack", ack, match);
            if (match) begin
                model_ptr = reg_byte % DEPTH;
            end
        end
        if (kind == 0) begin
            for (int i = 0; i < len; i++) begin
                busWriteByte(tx_buf[i], ack);
                checkOutput("data_ack", ack, match);
                if (match) begin
                    exp_q.push_back({4'(model_ptr), tx_buf[i]});
                    model_regs[model_ptr] = tx_buf[i];
                    model_ptr = (model_ptr + 1) % DEPTH;
                end
            end
            checkOutput("busy_frame", busy, match);
        end else begin
            if (kind == 1) begin
                busStart;
            end
            busWriteByte({addr7, 1'b1}, ack);
            checkOutput("addr_r_ack", ack, 1'b1);
            for (int i = 0; i < len; i++) begin
                busReadByte(rb, i < len - 1);
                checkOutput("rdata", rb, model_regs[model_ptr]);
                model_ptr = (model_ptr + 1) % DEPTH;
            end
            checkOutput("busy_after_nack", busy, 1'b1);
        end
        busStop;
        waitClk(4);
        checkOutput("busy_after_stop", busy, 1'b0);
        checkOutput("sda_released", sda_oe, 1'b0);
        checkWrites("frame");
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [6:0] a;
        logic [7:0] d;
        int         k;
        int         len;

        reset_n   = 1'b0;
        scl_m     = 1'b1;
        sda_m     = 1'b1;
        host_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            model_regs[i] = RESET_VAL;
        end
        model_ptr = 0;
        waitClk(5);
        checkOutput("rst_sda_oe", sda_oe, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_wr_pulse", wr_pulse, 1'b0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        reset_n = 1'b1;
        waitClk(5);
        checkRegs("rst_regs");

        tx_buf[0] = 8'h5A;
        applyStimulus(0, SLAVE_ADDR, 8'h03, 1);
        host_addr = 4'h3;
        #1;
        checkOutput("t1_host_rd", host_rdata, 8'h5A);

        tx_buf[0] = 8'hC3;
        tx_buf[1] = 8'h3C;
        applyStimulus(0, 7'h51, 8'h04, 2);
        checkRegs("t2_regs");

        tx_buf[0] = 8'h11;
        tx_buf[1] = 8'h22;
        tx_buf[2] = 8'h33;
        applyStimulus(0, SLAVE_ADDR, 8'h0F, 3);
        checkRegs("t3_regs");

        tx_buf[0] = 8'hAA;
        tx_buf[1] = 8'hBB;
        tx_buf[2] = 8'hCC;
        tx_buf[3] = 8'hDD;
        applyStimulus(0, SLAVE_ADDR, 8'h02, 4);
        applyStimulus(1, SLAVE_ADDR, 8'h02, 3);
        applyStimulus(2, SLAVE_ADDR, 8'h00, 1);

        for (int t = 0; t < 20; t++) begin
            k   = int'($urandom_range(0, 3));
            len = int'($urandom_range(1, 4));
            d   = 8'($urandom);
            for (int i = 0; i < 8; i++) begin
                tx_buf[i] = 8'($urandom);
            end
            case (k)
                0: applyStimulus(0, SLAVE_ADDR, d, len);
                1: applyStimulus(1, SLAVE_ADDR, d, len);
                2: applyStimulus(2, SLAVE_ADDR, d, len);
                default: begin
                    a = 7'($urandom_range(0, 127));
                    if (a == SLAVE_ADDR) begin
                        a = 7'h51;
                    end
                    applyStimulus(0, a, d, len);
                end
            endcase
        end
        checkRegs("rand_regs");

        wr_q.delete();
        busStart;
        busWriteByte({SLAVE_ADDR, 1'b0}, ack);
        checkOutput("t6_addr_ack", ack, 1'b1);
        busWriteByte(8'h09, ack);
        checkOutput("t6_reg_ack", ack, 1'b1);
        model_ptr = 9;
        d = 8'hB6;
        for (int i = 7; i >= 3; i--) begin
            sendBit(d[i], s);
        end
        busStop;
        waitClk(4);
        checkOutput("t6_busy", busy, 1'b0);
        checkOutput("t6_sda_oe", sda_oe, 1'b0);
        checkWrites("t6");
        applyStimulus(2, SLAVE_ADDR, 8'h00, 1);

        wr_q.delete();
        busStart;
        busWriteByte({SLAVE_ADDR, 1'b0}, ack);
        busWriteByte(8'h07, ack);
        d = 8'hFA;
        for (int i = 7; i >= 5; i--) begin
            sendBit(d[i], s);
        end
        checkOutput("t5_busy_before", busy, 1'b1);
        sda_m = d[4];
        waitClk(Q);
        scl_m = 1'b1;
        waitClk(2);
        reset_n = 1'b0;
        waitClk(1);
        checkOutput("t5_sda_oe", sda_oe, 1'b0);
        checkOutput("t5_busy", busy, 1'b0);
        checkOutput("t5_wr_pulse", wr_pulse, 1'b0);
        waitClk(1);
        reset_n = 1'b1;
        waitClk(Q);
        scl_m = 1'b0;
        waitClk(Q);
        for (int i = 3; i >= 0; i--) begin
            sendBit(d[i], s);
        end
        sendBit(1'b1, s);
        checkOutput("t5_nack", s, 1'b1);
        busStop;
        waitClk(4);
        for (int i = 0; i < DEPTH; i++) begin
            model_regs[i] = RESET_VAL;
        end
        model_ptr = 0;
        checkWrites("t5");
        checkRegs("t5_regs");
        tx_buf[0] = 8'h6D;
        tx_buf[1] = 8'h92;
        applyStimulus(0, SLAVE_ADDR, 8'h06, 2);
        checkRegs("t5_after_regs");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
